// File: rtl/dsp_frame_fifo.sv
// dsp_frame_fifo: packs per-channel sample strobes into NUM_CH-wide frames and
// buffers up to DEPTH frames behind a first-word-fall-through valid/ready port.
// Sticky flags report full-buffer pushes and sync/channel misalignment.
module dsp_frame_fifo #(
    parameter int PKT_WIDTH = 16,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 8,
    parameter int OVF_MODE  = 0
) (
    input  logic                        clkDSP_i,
    input  logic                        rstDSP_n_i,
    input  logic [PKT_WIDTH-1:0]        pktDSP_i,
    input  logic                        pktChangedDSP_i,
    input  logic                        frameSyncDSP_i,
    output logic [NUM_CH*PKT_WIDTH-1:0] frameDSP_o,
    output logic                        frameValidDSP_o,
    input  logic                        frameReadyDSP_i,
    output logic [$clog2(DEPTH+1)-1:0]  levelDSP_o,
    output logic                        overflowDSP_o,
    output logic                        misalignDSP_o,
    input  logic                        clrFlagsDSP_i
);

    localparam int FW = NUM_CH * PKT_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CW-1:0] ch_idx_q, ch_idx_d;
    logic [FW-1:0] part_q, part_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, mis_q, mis_d;
    logic [FW-1:0] mem_q [DEPTH];

    logic push, pop, full, wr_en, mis_set, ovf_set;

    // Assembler: walk chIdx over the channels, hunting for sync at channel 0.
    // part_d already holds the current sample, so it is the completed frame.
    always_comb begin
        part_d   = part_q;
        ch_idx_d = ch_idx_q;
        push     = 1'b0;
        mis_set  = 1'b0;
        if (pktChangedDSP_i) begin
            if (ch_idx_q == '0) begin
                if (frameSyncDSP_i) begin
                    part_d[0 +: PKT_WIDTH] = pktDSP_i;
                    if (NUM_CH == 1) push = 1'b1;
                    else             ch_idx_d = CW'(1);
                end else begin
                    mis_set = 1'b1;
                end
            end else if (frameSyncDSP_i) begin
                // Sync mid-frame: abandon the partial frame and restart on this sample.
                mis_set                = 1'b1;
                part_d[0 +: PKT_WIDTH] = pktDSP_i;
                ch_idx_d               = CW'(1);
            end else begin
                part_d[int'(ch_idx_q)*PKT_WIDTH +: PKT_WIDTH] = pktDSP_i;
                if (ch_idx_q == CW'(NUM_CH - 1)) begin
                    push     = 1'b1;
                    ch_idx_d = '0;
                end else begin
                    ch_idx_d = ch_idx_q + CW'(1);
                end
            end
        end
    end

    // Buffer control: level is kept apart from the pointers so full/empty never alias.
    always_comb begin
        pop      = frameValidDSP_o && frameReadyDSP_i;
        full     = (level_q == LW'(DEPTH));
        wr_en    = 1'b0;
        ovf_set  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            level_d  = level_q - LW'(1);
        end
        if (push) begin
            if (!full || pop) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                level_d  = pop ? level_q : level_q + LW'(1);
            end else begin
                ovf_set = 1'b1;
                if (OVF_MODE == 1) begin
                    // Overwrite the oldest slot; the read side skips past it.
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
        end
    end

    // Sticky flags: a set event in the same cycle wins over a clear.
    always_comb begin
        ovf_d = ovf_set ? 1'b1 : (clrFlagsDSP_i ? 1'b0 : ovf_q);
        mis_d = mis_set ? 1'b1 : (clrFlagsDSP_i ? 1'b0 : mis_q);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clkDSP_i or negedge rstDSP_n_i) begin
        if (!rstDSP_n_i) begin
            ch_idx_q <= '0;
            part_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            ch_idx_q <= ch_idx_d;
            part_q   <= part_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
        end
    end

    // Frame storage; contents are never reset, validity comes from the level.
    always_ff @(posedge clkDSP_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= part_d;
    end

    assign frameValidDSP_o = (level_q != '0);
    assign frameDSP_o      = frameValidDSP_o ? mem_q[rd_ptr_q] : '0;
    assign levelDSP_o      = level_q;
    assign overflowDSP_o   = ovf_q;
    assign misalignDSP_o   = mis_q;

endmodule

// File: tb/tb_dsp_frame_fifo.sv
// Self-checking bench: two DUTs (drop and overwrite policy) share one stimulus
// stream and are compared every cycle against a queue-based frame model.
module tb_dsp_frame_fifo;

    localparam int PW  = 16;
    localparam int NCH = 2;
    localparam int DEP = 8;
    localparam int FW  = PW * NCH;
    localparam int LW  = $clog2(DEP + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [PW-1:0] pkt = '0;
    logic strb = 1'b0, sync = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [FW-1:0] f0, f1;
    logic v0, v1, o0, o1, mi0, mi1;
    logic [LW-1:0] l0, l1;

    always #5 clk = ~clk;

    dsp_frame_fifo #(.PKT_WIDTH(PW), .NUM_CH(NCH), .DEPTH(DEP), .OVF_MODE(0)) u_dut0 (
        .clkDSP_i(clk), .rstDSP_n_i(rst_n), .pktDSP_i(pkt), .pktChangedDSP_i(strb),
        .frameSyncDSP_i(sync), .frameDSP_o(f0), .frameValidDSP_o(v0), .frameReadyDSP_i(rdy),
        .levelDSP_o(l0), .overflowDSP_o(o0), .misalignDSP_o(mi0), .clrFlagsDSP_i(clr));

    dsp_frame_fifo #(.PKT_WIDTH(PW), .NUM_CH(NCH), .DEPTH(DEP), .OVF_MODE(1)) u_dut1 (
        .clkDSP_i(clk), .rstDSP_n_i(rst_n), .pktDSP_i(pkt), .pktChangedDSP_i(strb),
        .frameSyncDSP_i(sync), .frameDSP_o(f1), .frameValidDSP_o(v1), .frameReadyDSP_i(rdy),
        .levelDSP_o(l1), .overflowDSP_o(o1), .misalignDSP_o(mi1), .clrFlagsDSP_i(clr));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: frames as queue entries, channels gathered in an array.
    logic [FW-1:0] q0[$];
    logic [FW-1:0] q1[$];
    logic [PW-1:0] m_part[NCH];
    int m_ch;
    bit m_ovf0, m_ovf1, m_mis;

    typedef struct {
        logic [PW-1:0] pkt;
        bit            strb, sync, rdy, clr;
        bit            e_vld;
        int            e_lvl;
        logic [FW-1:0] e_frame;
        bit            e_mis;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ch   = 0;
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step();
        bit push = 1'b0;
        logic [FW-1:0] nf = '0;
        if (clr) begin
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
            m_mis  = 1'b0;
        end
        if (strb) begin
            if (sync) begin
                if (m_ch != 0) m_mis = 1'b1;
                m_part[0] = pkt;
                m_ch = 1;
            end else if (m_ch == 0) begin
                m_mis = 1'b1;
            end else begin
                m_part[m_ch] = pkt;
                m_ch++;
            end
            if (m_ch == NCH) begin
                push = 1'b1;
                m_ch = 0;
                for (int c = 0; c < NCH; c++) nf[c*PW +: PW] = m_part[c];
            end
        end
        // Drop policy.
        if (rdy && q0.size() != 0) void'(q0.pop_front());
        if (push) begin
            if (q0.size() < DEP) q0.push_back(nf);
            else m_ovf0 = 1'b1;
        end
        // Overwrite policy.
        if (rdy && q1.size() != 0) void'(q1.pop_front());
        if (push) begin
            if (q1.size() == DEP) begin
                void'(q1.pop_front());
                m_ovf1 = 1'b1;
            end
            q1.push_back(nf);
        end
    endtask

    task automatic check_model();
        chk("m0_valid", 64'(v0), 64'(q0.size() != 0));
        chk("m0_level", 64'(l0), 64'(q0.size()));
        chk("m0_frame", 64'(f0), (q0.size() != 0) ? 64'(q0[0]) : 64'd0);
        chk("m0_ovf",   64'(o0), 64'(m_ovf0));
        chk("m0_mis",   64'(mi0), 64'(m_mis));
        chk("m1_valid", 64'(v1), 64'(q1.size() != 0));
        chk("m1_level", 64'(l1), 64'(q1.size()));
        chk("m1_frame", 64'(f1), (q1.size() != 0) ? 64'(q1[0]) : 64'd0);
        chk("m1_ovf",   64'(o1), 64'(m_ovf1));
        chk("m1_mis",   64'(mi1), 64'(m_mis));
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one.
    task automatic drive(input logic [PW-1:0] p, input bit s, input bit sy, input bit r, input bit c);
        pkt = p; strb = s; sync = sy; rdy = r; clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic push_frame(input int i, input bit r);
        for (int c = 0; c < NCH; c++) drive(PW'(i + 100 * c), 1'b1, c == 0, r, 1'b0);
    endtask

    task automatic add(input logic [PW-1:0] p, input bit s, input bit sy, input bit r, input bit c,
                       input bit ev, input int el, input logic [FW-1:0] ef, input bit em);
        vec_t v;
        v.pkt = p; v.strb = s; v.sync = sy; v.rdy = r; v.clr = c;
        v.e_vld = ev; v.e_lvl = el; v.e_frame = ef; v.e_mis = em;
        tbl.push_back(v);
    endtask

    initial begin
        bit s, sy, r, c;
        int pct;

        // pkt, strb, sync, rdy, clr | valid, level, frame, misalign
        add(16'hAAAA, 1, 1, 0, 0,  0, 0, 32'h0,          0);
        add(16'h5555, 0, 1, 0, 0,  0, 0, 32'h0,          0);
        add(16'hBBBB, 1, 0, 0, 0,  1, 1, 32'hBBBB_AAAA,  0);
        add(16'h0000, 0, 0, 1, 0,  0, 0, 32'h0,          0);
        add(16'h1234, 1, 0, 0, 0,  0, 0, 32'h0,          1);
        add(16'h5678, 1, 1, 0, 0,  0, 0, 32'h0,          1);
        add(16'h9999, 1, 0, 0, 0,  1, 1, 32'h9999_5678,  1);
        add(16'h0000, 0, 0, 0, 1,  1, 1, 32'h9999_5678,  0);
        add(16'h1111, 1, 1, 0, 0,  1, 1, 32'h9999_5678,  0);
        add(16'h2222, 1, 1, 0, 0,  1, 1, 32'h9999_5678,  1);
        add(16'h3333, 1, 0, 0, 0,  1, 2, 32'h9999_5678,  1);
        add(16'h0000, 0, 0, 1, 0,  1, 1, 32'h3333_2222,  1);
        add(16'h0000, 0, 0, 1, 1,  0, 0, 32'h0,          0);

        // Power-on reset and reset-state check.
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_model();
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_level", 64'(l1), 64'd0);
        rst_n = 1'b1;

        // Table: assembly, idle-cycle masking, misalignment, mid-frame resync.
        foreach (tbl[i]) begin
            drive(tbl[i].pkt, tbl[i].strb, tbl[i].sync, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_valid", i), 64'(v0), 64'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_level", i), 64'(l0), 64'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_frame", i), 64'(f0), 64'(tbl[i].e_frame));
            chk($sformatf("tbl%0d_mis", i),   64'(mi0), 64'(tbl[i].e_mis));
        end

        // Overflow: nine frames into an eight-deep buffer with no consumer.
        for (int i = 0; i < 9; i++) push_frame(i, 1'b0);
        chk("ovf_level0", 64'(l0), 64'd8);
        chk("ovf_head0",  64'(f0), 64'h0064_0000);
        chk("ovf_flag0",  64'(o0), 64'd1);
        chk("ovf_level1", 64'(l1), 64'd8);
        chk("ovf_head1",  64'(f1), 64'h0065_0001);
        chk("ovf_flag1",  64'(o1), 64'd1);
        drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_flag0", 64'(o0), 64'd0);
        chk("clr_flag1", 64'(o1), 64'd0);
        // Push and pop on the same edge while full: legal, no overflow.
        drive(16'h00AA, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(16'h00BB, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pp_level0", 64'(l0), 64'd8);
        chk("pp_level1", 64'(l1), 64'd8);
        chk("pp_flag0",  64'(o0), 64'd0);
        chk("pp_flag1",  64'(o1), 64'd0);
        chk("pp_head0",  64'(f0), 64'h0065_0001);
        repeat (10) drive('0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Ordering across pointer wrap with a toggling consumer.
        r = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                drive(PW'(i + 100 * ch), 1'b1, ch == 0, r, 1'b0);
                r = ~r;
            end
        end
        chk("wrap_flag0", 64'(o0), 64'd0);
        repeat (12) drive('0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic, alternating fill-heavy and drain-heavy phases.
        for (int k = 0; k < 3000; k++) begin
            s   = ($urandom_range(0, 99) < 60);
            sy  = (m_ch == 0);
            if ($urandom_range(0, 19) == 0) sy = ~sy;
            pct = ((k % 1000) < 500) ? 20 : 75;
            r   = ($urandom_range(0, 99) < pct);
            c   = ($urandom_range(0, 63) == 0);
            drive(PW'($urandom), s, sy, r, c);
        end

        // Asynchronous reset with three frames queued and a frame half built.
        repeat (10) drive('0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push_frame(20 + i, 1'b0);
        drive(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(16'hC0DE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(l0), 64'd3);
        chk("pre_rst_mis",   64'(mi0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid0", 64'(v0), 64'd0);
        chk("arst_level0", 64'(l0), 64'd0);
        chk("arst_frame0", 64'(f0), 64'd0);
        chk("arst_mis0",   64'(mi0), 64'd0);
        chk("arst_valid1", 64'(v1), 64'd0);
        chk("arst_level1", 64'(l1), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
        drive(16'hCAFE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_empty", 64'(v0), 64'd0);
        drive(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_level", 64'(l0), 64'd1);
        chk("post_rst_frame", 64'(f0), 64'hBEEF_CAFE);
        chk("post_rst_mis",   64'(mi1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
